mem_port_arbiter: RTL and testbench

- Shares one single-port memory between the instruction-fetch side (fetch stage) and the data side (load/store in the memory stage).
- One outstanding transaction at a time; responses return in order.
- Data side wins conflicts, except directly after its own grant, when fetch wins.
- A fetch flush discards an in-flight fetch response, and a watchdog stops a non-responding memory from hanging the pipeline.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch and the data side.
// Only one transaction is outstanding at a time. In a conflict the data side
// wins, except directly after its own grant. A fetch flush discards the
// in-flight fetch response. A watchdog aborts a transaction when the memory
// does not respond.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   i_req/i_addr/i_flush    fetch request, byte address, redirect
//   i_gnt/i_rvalid/i_rdata  fetch accept pulse, response valid and data
//   d_req/d_we/d_addr/d_wdata/d_be  data request (load/store) fields
//   d_gnt/d_rvalid/d_rdata  data accept pulse, load data / store ack
//   m_req/m_we/m_addr/m_wdata/m_be  memory request and its fields
//   m_ready                 memory accepts the request when m_req & m_ready
//   m_rvalid/m_rdata        memory response
//   busy                    a transaction is outstanding
//   err                     one-cycle pulse on watchdog abort
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state, state_nxt;
  logic        last_d;
  logic        kill;
  logic [31:0] cnt;

  logic sel_d, sel_i, accept, tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b0;
      kill   <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (i_gnt || d_gnt) last_d <= d_gnt;
      if (state_nxt == IDLE)
        kill <= 1'b0;
      else if (i_flush && (state == BUSY_I || i_gnt))
        kill <= 1'b1;
      // Counter holds zero in IDLE so every BUSY period starts counting from 0.
      if (state == IDLE)
        cnt <= '0;
      else if (!m_rvalid)
        cnt <= cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_be      = '0;
    err       = 1'b0;
    busy      = (state != IDLE);
    tmo       = 1'b0;
    accept    = 1'b0;

    // Data wins a conflict unless the previous grant went to the data side.
    sel_d = d_req && (!i_req || !last_d);
    sel_i = i_req && !sel_d;

    case (state)
      IDLE: begin
        m_req  = i_req || d_req;
        accept = (i_req || d_req) && m_ready;
        if (sel_d) begin
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_be    = d_be;
        end else if (sel_i) begin
          m_addr  = i_addr;
          m_be    = 4'hF;
        end
        i_gnt = accept && sel_i;
        d_gnt = accept && sel_d;
        if (accept) state_nxt = sel_d ? BUSY_D : BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        tmo = (TIMEOUT_CYC != 0) && !m_rvalid && (cnt == 32'(TIMEOUT_CYC));
        err = tmo;
        if (m_rvalid || tmo) begin
          state_nxt = IDLE;
          if (state == BUSY_D) begin
            d_rvalid = 1'b1;
            d_rdata  = m_rvalid ? m_rdata : '0;
          end else if (!kill && !i_flush) begin
            i_rvalid = 1'b1;
            i_rdata  = m_rvalid ? m_rdata : '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_flush, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .err(err)
  );

  typedef struct {
    bit          d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gnt_t;

  typedef struct {
    bit          iv;
    bit          dv;
    bit          chkdata;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  gnt_t mg;
  rsp_t mr;
  int   total = 0;
  int   bad   = 0;

  // Per-cycle expectations written by the stimulus side.
  bit exp_busy = 0, exp_gnt_now = 0, exp_evt = 0;

  // Reference model state: pending requests and who won the last grant.
  bit          i_pend = 0, d_pend = 0, last_d = 0;
  logic [31:0] ia = '0, da = '0, dw = '0;
  logic        dwe = 1'b0;
  logic [3:0]  dbe = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each event.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("busy", busy, exp_busy);
      chk("m_req", m_req, !exp_busy && (i_req || d_req));
      chk("gnt_timing", i_gnt | d_gnt, exp_gnt_now);
      chk("rsp_timing", i_rvalid | d_rvalid | err, exp_evt);
      if (i_rvalid !== 1'b1) chk("i_rdata_quiet", i_rdata, 0);
      if (d_rvalid !== 1'b1) chk("d_rdata_quiet", d_rdata, 0);
      if (i_gnt === 1'b1 || d_gnt === 1'b1) begin
        if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
        else begin
          mg = gq.pop_front();
          chk("gnt_side", {i_gnt, d_gnt}, {!mg.d, mg.d});
          chk("m_addr", m_addr, mg.addr);
          chk("m_we", m_we, mg.we);
          chk("m_wdata", m_wdata, mg.wdata);
          chk("m_be", m_be, mg.be);
        end
      end
      if (i_rvalid === 1'b1 || d_rvalid === 1'b1 || err === 1'b1) begin
        if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          mr = rq.pop_front();
          chk("i_rvalid", i_rvalid, mr.iv);
          chk("d_rvalid", d_rvalid, mr.dv);
          chk("err", err, mr.err);
          if (mr.iv) chk("i_rdata", i_rdata, mr.data);
          if (mr.dv && mr.chkdata) chk("d_rdata", d_rdata, mr.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    exp_busy = 0; exp_gnt_now = 0; exp_evt = 0;
  endtask

  task automatic drive_reqs();
    i_req = i_pend; i_addr = ia;
    d_req = d_pend; d_we = dwe; d_addr = da; d_wdata = dw; d_be = dbe;
  endtask

  task automatic set_i(input logic [31:0] a);
    i_pend = 1; ia = a;
    drive_reqs();
  endtask

  task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] be);
    d_pend = 1; dwe = we; da = a; dw = w; dbe = be;
    drive_reqs();
  endtask

  task automatic idle_wait(input int n);
    for (int k = 0; k < n; k++) begin
      m_ready = 0;
      i_flush = ($urandom_range(0, 3) == 0);
      cyc();
      i_flush = 0;
    end
  endtask

  // One transaction. lat: response in BUSY cycle lat (0 = memory never answers).
  // flush_at: cycle of i_flush, 0 = acceptance cycle (-1 none).
  // rst_at: BUSY cycle in which reset is pulsed (0 none).
  // rehold: winner keeps requesting with the same fields after its grant.
  task automatic run_txn(input int lat, input int flush_at, input int rst_at,
                         input logic [31:0] rd, input bit rehold);
    bit   wd, killed, pushed;
    int   nb;
    gnt_t g;
    rsp_t r;
    wd      = d_pend && (!i_pend || !last_d);
    g.d     = wd;
    g.addr  = wd ? da : ia;
    g.we    = wd ? dwe : 1'b0;
    g.wdata = wd ? dw : 32'h0;
    g.be    = wd ? dbe : 4'hF;
    gq.push_back(g);
    nb      = (rst_at > 0) ? rst_at : ((lat == 0) ? int'(TO) + 1 : lat);
    killed  = !wd && flush_at >= 0 && flush_at <= nb;
    pushed  = 0;
    if (rst_at == 0) begin
      r.iv      = !wd && !killed;
      r.dv      = wd;
      r.err     = (lat == 0);
      r.chkdata = !(wd && dwe);
      r.data    = (lat == 0) ? 32'h0 : rd;
      if (r.iv || r.dv || r.err) begin
        rq.push_back(r);
        pushed = 1;
      end
    end
    // acceptance cycle
    drive_reqs();
    m_ready = 1; m_rvalid = 0; i_flush = (flush_at == 0);
    exp_gnt_now = 1;
    cyc();
    last_d = wd;
    if (!rehold) begin
      if (wd) d_pend = 0; else i_pend = 0;
    end
    drive_reqs();
    m_ready = 0; i_flush = 0;
    for (int c = 1; c <= nb; c++) begin
      exp_busy = 1;
      i_flush  = (flush_at == c);
      if (rst_at == c) reset = 1;
      else if (rst_at == 0 && lat != 0 && c == lat) begin
        m_rvalid = 1; m_rdata = rd;
      end else m_rdata = $urandom;
      exp_evt = (c == nb) && pushed;
      cyc();
      m_rvalid = 0; m_rdata = 0; reset = 0; i_flush = 0;
    end
    if (rst_at != 0) last_d = 0;
    if (rst_at != 0 || lat == 0) begin
      // Late response while IDLE must be dropped.
      m_ready = 0; m_rvalid = 1; m_rdata = $urandom;
      cyc();
      m_rvalid = 0; m_rdata = 0;
    end
  endtask

  initial begin
    int k, lat, rst, fl;
    reset = 1; i_flush = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
    drive_reqs();
    repeat (3) cyc();
    reset = 0;
    idle_wait(0);
    cyc(); cyc();

    // fetch only, latency 1
    set_i(32'h0000_0010);
    run_txn(1, -1, 0, 32'h0050_0093, 0);
    // conflict after reset: data, fetch, data, fetch
    set_i(32'h0000_0040);
    set_d(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    repeat (4) run_txn(1, -1, 0, $urandom, 1);
    i_pend = 0; d_pend = 0; drive_reqs();
    cyc();
    // flush the cycle after the grant, latency 3, then a normal fetch
    set_i(32'h0000_0080);
    run_txn(3, 1, 0, $urandom, 0);
    set_i(32'h0000_0084);
    run_txn(1, -1, 0, 32'h1234_5678, 0);
    // store
    set_d(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
    run_txn(2, -1, 0, $urandom, 0);
    // flush during a data access has no effect
    set_d(1'b0, 32'h0000_0204, 32'h0, 4'hF);
    run_txn(2, 1, 0, 32'hCAFE_F00D, 0);
    // watchdog on fetch and on a load
    set_i(32'h0000_0090);
    run_txn(0, -1, 0, 32'h0, 0);
    set_d(1'b0, 32'h0000_0300, 32'h0, 4'hF);
    run_txn(0, -1, 0, 32'h0, 0);
    // reset during BUSY_D
    set_d(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    run_txn(3, -1, 2, $urandom, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!i_pend && $urandom_range(0, 2) != 0) set_i($urandom);
      if (!d_pend && $urandom_range(0, 2) != 0)
        set_d(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (!i_pend && !d_pend) set_i($urandom);
      idle_wait($urandom_range(0, 2));
      k   = $urandom_range(0, 19);
      lat = (k == 0) ? 0 : $urandom_range(1, TO);
      rst = (k == 1) ? $urandom_range(1, 3) : 0;
      fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      run_txn(lat, fl, rst, $urandom, ($urandom_range(0, 3) == 0));
    end

    i_pend = 0; d_pend = 0; drive_reqs();
    repeat (3) cyc();
    chk("gnt_queue_empty", gq.size(), 0);
    chk("rsp_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
